// File: rtl/prg_uploader_pkg.sv
// Shared constants, FSM states and stream beat type for the PRG uploader and loader.
package prg_uploader_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] TXTTAB_ADDR_DEF = 16'h0028;
    localparam logic [ADDR_W-1:0] VARTAB_ADDR_DEF = 16'h002A;
    localparam logic [ADDR_W-1:0] MEM_TOP_DEF     = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_CHECK,
        S_HDR,
        S_FETCH,
        S_SEND,
        S_FINISH
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
    } prg_beat_t;

    // Pointer bytes are read as TXTTAB, TXTTAB+1, VARTAB, VARTAB+1.
    function automatic logic [ADDR_W-1:0] ptr_read_addr(input logic [1:0] idx,
                                                        input logic [ADDR_W-1:0] txttab,
                                                        input logic [ADDR_W-1:0] vartab);
        return (idx[1] ? vartab : txttab) + ADDR_W'(idx[0]);
    endfunction

endpackage

// File: rtl/prg_mem_fetch.sv
// Single-byte read engine for a registered-output SRAM with two-edge read latency.
module prg_mem_fetch
    import prg_uploader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid
);

    logic rd_d1;

    // mem_din is sampled on the second edge after mem_rd rises; flush kills any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            rd_d1      <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            mem_rd     <= req && !flush;
            rd_d1      <= mem_rd && !flush;
            byte_valid <= rd_d1 && !flush;
            if (req && !flush) begin
                mem_addr <= addr;
            end
            if (rd_d1) begin
                byte_data <= mem_din;
            end
        end
    end

endmodule

// File: rtl/prg_uploader.sv
// Dumps the resident BASIC program (TXTTAB..VARTAB) as a PRG byte stream with a 2-byte load-address header.
module prg_uploader
    import prg_uploader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TXTTAB_ADDR = TXTTAB_ADDR_DEF,
    parameter logic [ADDR_W-1:0] VARTAB_ADDR = VARTAB_ADDR_DEF,
    parameter logic [ADDR_W-1:0] MEM_TOP     = MEM_TOP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_nxt;
    logic [1:0]        ptr_idx_q, ptr_idx_nxt;
    logic              pend_q, pend_nxt;
    logic [ADDR_W-1:0] start_ptr_q, start_ptr_nxt;
    logic [ADDR_W-1:0] end_ptr_q, end_ptr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    prg_beat_t         beat_q, beat_nxt;
    logic              out_valid_nxt, busy_nxt, done_nxt, error_nxt;

    logic              fetch_req_c;
    logic              flush_c;
    logic [ADDR_W-1:0] fetch_addr_c;
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;

    assign out_data  = beat_q.data;
    assign out_index = beat_q.index;

    prg_mem_fetch u_fetch (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_c),
        .req        (fetch_req_c),
        .addr       (fetch_addr_c),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_din    (mem_din),
        .byte_data  (byte_data),
        .byte_valid (byte_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_idx_q   <= '0;
            pend_q      <= 1'b0;
            start_ptr_q <= '0;
            end_ptr_q   <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            ptr_idx_q   <= ptr_idx_nxt;
            pend_q      <= pend_nxt;
            start_ptr_q <= start_ptr_nxt;
            end_ptr_q   <= end_ptr_nxt;
            addr_q      <= addr_nxt;
            beat_q      <= beat_nxt;
            out_valid   <= out_valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        ptr_idx_nxt   = ptr_idx_q;
        pend_nxt      = pend_q;
        start_ptr_nxt = start_ptr_q;
        end_ptr_nxt   = end_ptr_q;
        addr_nxt      = addr_q;
        beat_nxt      = beat_q;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;
        fetch_req_c   = 1'b0;
        fetch_addr_c  = addr_q;
        flush_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_valid_nxt = 1'b0;
                if (start && !abort) begin
                    state_nxt   = S_PTR;
                    ptr_idx_nxt = '0;
                    pend_nxt    = 1'b0;
                end
            end
            S_PTR: begin
                if (byte_valid) begin
                    case (ptr_idx_q)
                        2'd0:    start_ptr_nxt[7:0]  = byte_data;
                        2'd1:    start_ptr_nxt[15:8] = byte_data;
                        2'd2:    end_ptr_nxt[7:0]    = byte_data;
                        default: end_ptr_nxt[15:8]   = byte_data;
                    endcase
                    pend_nxt    = 1'b0;
                    ptr_idx_nxt = 2'(ptr_idx_q + 2'd1);
                    if (ptr_idx_q == 2'd3) begin
                        state_nxt = S_CHECK;
                    end
                end else if (!pend_q) begin
                    fetch_req_c  = 1'b1;
                    fetch_addr_c = ptr_read_addr(ptr_idx_q, TXTTAB_ADDR, VARTAB_ADDR);
                    pend_nxt     = 1'b1;
                end
            end
            S_CHECK: begin
                if (end_ptr_q <= start_ptr_q || end_ptr_q > MEM_TOP) begin
                    error_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt     = S_HDR;
                    addr_nxt      = start_ptr_q;
                    beat_nxt      = '{index: '0, data: start_ptr_q[7:0]};
                    out_valid_nxt = 1'b1;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    if (beat_q.index == '0) begin
                        beat_nxt = '{index: ADDR_W'(1), data: start_ptr_q[15:8]};
                    end else begin
                        out_valid_nxt = 1'b0;
                        pend_nxt      = 1'b0;
                        state_nxt     = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (byte_valid) begin
                    beat_nxt      = '{index: ADDR_W'(beat_q.index + ADDR_W'(1)), data: byte_data};
                    out_valid_nxt = 1'b1;
                    pend_nxt      = 1'b0;
                    state_nxt     = S_SEND;
                end else if (!pend_q) begin
                    fetch_req_c = 1'b1;
                    pend_nxt    = 1'b1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    addr_nxt      = ADDR_W'(addr_q + ADDR_W'(1));
                    if (ADDR_W'(addr_q + ADDR_W'(1)) == end_ptr_q) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including a same-cycle handshake.
        if (abort && state_q != S_IDLE) begin
            state_nxt     = S_IDLE;
            out_valid_nxt = 1'b0;
            done_nxt      = 1'b0;
            error_nxt     = 1'b0;
            pend_nxt      = 1'b0;
            fetch_req_c   = 1'b0;
            flush_c       = 1'b1;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule
